// File: rtl/pkt_filter_pkg.sv
// pkt_filter_pkg: shared constants, tuple layout and parser states for the packet filter.
package pkt_filter_pkg;
   localparam logic [7:0] PROTO_TCP = 8'd6;
   localparam logic [7:0] PROTO_UDP = 8'd17;
   localparam logic [5:0] OFF_PROTO = 6'd9;
   localparam logic [5:0] OFF_SRC = 6'd12;
   localparam logic [5:0] OFF_DST = 6'd16;
   localparam int IPP_W = 72;
   localparam int PORT_W = 18;
   typedef enum logic [2:0] {IDLE, L2, IP, L4, DRAIN} state_t;
   typedef struct packed {
      logic [IPP_W-1:0] ip_protocol;
      logic [PORT_W-1:0] src_port;
      logic [PORT_W-1:0] dst_port;
   } tuple_t;
endpackage

// File: rtl/tuple_out_reg.sv
// tuple_out_reg: 108-bit tuple holding register presented to the filter core under valid/ready.
module tuple_out_reg
   import pkt_filter_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  tuple_t next_tuple,
   input  logic   ready,
   output logic   valid,
   output tuple_t held
);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         valid <= 1'b0;
         held <= '0;
      end else begin
         if (load) held <= next_tuple;
         valid <= load | (valid & ~ready);
      end
endmodule

// File: rtl/tuple_extractor.sv
// tuple_extractor: parses an Ethernet/IPv4 byte stream into the filter's 5-tuple.
module tuple_extractor
   import pkt_filter_pkg::*;
#(
   parameter int ETH_HDR_BYTES = 14,
   parameter int CNT_W = 16
)(
   input  logic              test_clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   input  logic              in_sop,
   input  logic              in_eop,
   output logic              in_ready,
   output logic [IPP_W-1:0]  ip_protocol,
   output logic [PORT_W-1:0] src_port,
   output logic [PORT_W-1:0] dst_port,
   output logic              tuple_valid,
   input  logic              tuple_ready,
   output logic              err,
   output logic [CNT_W-1:0]  drop_cnt
);
   localparam logic [5:0] L2_LAST = 6'(ETH_HDR_BYTES - 1);
   localparam state_t SOP_STATE = (ETH_HDR_BYTES == 0) ? IP : L2;
   state_t state, state_n, es;
   logic [5:0] cnt, cnt_n, ec;
   logic [3:0] ihl, ihl_n;
   logic [7:0] proto, proto_n;
   logic [31:0] src_ip, src_n, dst_ip, dst_n;
   logic [15:0] sport, sport_n, dport, dport_n;
   logic acc, sop_acc, ok_hdr, emit, err_n;
   tuple_t nt, tq;
   assign in_ready = ~rst & ~(state == IDLE & tuple_valid);
   assign acc = in_valid & in_ready;
   assign sop_acc = acc & in_sop;
   // A sop byte always restarts parsing as byte 0 of the first header.
   assign es = sop_acc ? SOP_STATE : state;
   assign ec = sop_acc ? 6'd0 : cnt;
   assign ok_hdr = in_data[7:4] == 4'd4 && in_data[3:0] >= 4'd5;
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      ihl_n = ihl;
      proto_n = proto;
      src_n = src_ip;
      dst_n = dst_ip;
      sport_n = sport;
      dport_n = dport;
      emit = 1'b0;
      err_n = sop_acc & (state != IDLE);
      if (acc) begin
         state_n = es;
         cnt_n = (ec == 6'h3F) ? ec : ec + 6'd1;
         case (es)
            L2:
               if (in_eop) begin
                  err_n = 1'b1;
                  state_n = IDLE;
               end else if (ec == L2_LAST) state_n = IP;
            IP: begin
               if (ec == 6'd0) ihl_n = in_data[3:0];
               if (ec == OFF_PROTO) proto_n = in_data;
               if (ec >= OFF_SRC && ec < OFF_SRC + 6'd4) src_n = {src_ip[23:0], in_data};
               if (ec >= OFF_DST && ec < OFF_DST + 6'd4) dst_n = {dst_ip[23:0], in_data};
               if (ec == 6'd0 && !ok_hdr) begin
                  err_n = 1'b1;
                  state_n = in_eop ? IDLE : DRAIN;
               end else if (ec == {ihl_n, 2'b00} - 6'd1 && proto_n != PROTO_TCP && proto_n != PROTO_UDP) begin
                  emit = 1'b1;
                  state_n = in_eop ? IDLE : DRAIN;
               end else if (in_eop) begin
                  err_n = 1'b1;
                  state_n = IDLE;
               end else if (ec == {ihl_n, 2'b00} - 6'd1) state_n = L4;
            end
            L4: begin
               if (ec < 6'd2) sport_n = {sport[7:0], in_data};
               else if (ec < 6'd4) dport_n = {dport[7:0], in_data};
               if (ec == 6'd3) begin
                  emit = 1'b1;
                  state_n = in_eop ? IDLE : DRAIN;
               end else if (in_eop) begin
                  err_n = 1'b1;
                  state_n = IDLE;
               end
            end
            DRAIN: state_n = in_eop ? IDLE : DRAIN;
            default: state_n = IDLE;
         endcase
         if (state_n != es) cnt_n = 6'd0;
      end
   end
   assign nt.ip_protocol = {src_n, dst_n, proto_n};
   assign nt.src_port = (es == L4) ? {2'b00, sport_n} : '0;
   assign nt.dst_port = (es == L4) ? {2'b00, dport_n} : '0;
   always_ff @(posedge test_clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         ihl <= '0;
         proto <= '0;
         src_ip <= '0;
         dst_ip <= '0;
         sport <= '0;
         dport <= '0;
         err <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         ihl <= ihl_n;
         proto <= proto_n;
         src_ip <= src_n;
         dst_ip <= dst_n;
         sport <= sport_n;
         dport <= dport_n;
         err <= err_n;
         drop_cnt <= drop_cnt + CNT_W'(err_n);
      end
   tuple_out_reg u_out (
      .clk(test_clk),
      .rst(rst),
      .load(emit),
      .next_tuple(nt),
      .ready(tuple_ready),
      .valid(tuple_valid),
      .held(tq)
   );
   assign ip_protocol = tq.ip_protocol;
   assign src_port = tq.src_port;
   assign dst_port = tq.dst_port;
endmodule

// File: doc/tuple_extractor.md
# tuple_extractor

Front-end parser for the packet filter. It accepts a byte-wide Ethernet/IPv4 packet stream and extracts the classification tuple: source IP, destination IP, protocol, source port and destination port. It presents that tuple to the filter core in the exact packed format the core consumes on `ip_protocol`, `src_port` and `dst_port`. It is the producer end of the filter's tuple interface and holds each tuple under a valid/ready handshake until the core accepts it.

## Interface
- `ETH_HDR_BYTES`, 14: L2 header bytes skipped before the IPv4 header (0 means the stream starts at IPv4).
- `CNT_W`, 16: width of the drop counter.
- `test_clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_data` in 8: stream byte, network order.
- `in_valid` in 1: `in_data` valid.
- `in_sop` in 1: first byte of packet (qualified by `in_valid`).
- `in_eop` in 1: last byte of packet (qualified by `in_valid`).
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `ip_protocol` out 72: {src_ip[31:0], dst_ip[31:0], proto[7:0]}.
- `src_port` out 18: {2'b00, L4 source port}.
- `dst_port` out 18: {2'b00, L4 destination port}.
- `tuple_valid` out 1: tuple fields stable and valid.
- `tuple_ready` in 1: core accepts the tuple when `tuple_valid && tuple_ready`.
- `err` out 1: one-cycle pulse when a packet is dropped as malformed.
- `drop_cnt` out CNT_W: count of malformed packets, wraps.

## Operation
- FSM states: IDLE, L2, IP, L4, DRAIN.
- IDLE:
  - Waits for an accepted byte with `in_sop`.
  - Enters IP if `ETH_HDR_BYTES` == 0, else L2.
  - The sop byte is counted as byte 0 of the corresponding header.
  - A byte without sop in IDLE is discarded silently.
- L2: skips `ETH_HDR_BYTES` bytes, then enters IP.
- IP byte capture, with offsets relative to the IPv4 header:
  - Byte 0: version, must be 4; IHL, must be ≥5.
  - Byte 9: proto.
  - Bytes 12–15: src_ip.
  - Bytes 16–19: dst_ip.
- IP exit:
  - After byte IHL*4−1, go to L4 if proto is 6 or 17.
  - Otherwise emit the tuple with both ports 0 and go to DRAIN.
- L4 byte capture, relative to the L4 header: bytes 0–1 are the source port and bytes 2–3 the destination port. After byte 3, emit the tuple and go to DRAIN.
- DRAIN: discard bytes until `in_eop`, then go to IDLE.
- Emit:
  - Load the output registers and set `tuple_valid`.
  - Fields are held unchanged while `tuple_valid` is high.
  - `tuple_valid` clears on the cycle after the handshake.
- Malformed packet: bad version, IHL<5, or `in_eop` before emit.
  - Pulse `err`, increment `drop_cnt`, and emit no tuple.
  - If `in_eop` ended the packet, go to IDLE; otherwise go to DRAIN.
- `in_sop` seen in any state other than IDLE: the current packet is malformed and is dropped with `err`. The sop byte starts the new packet, so the FSM goes to L2 or IP.
- Back-pressure:
  - `in_ready` = 0 only when the FSM is in IDLE and `tuple_valid` = 1.
  - Drain of the previous packet proceeds while its tuple is pending.
- Header byte counter: 6 bits, enough for a 60-byte IPv4 header. It is reset on each state entry and never wraps within a state.

## Timing
- Reset values:
  - `tuple_valid`, `err`, `in_ready` and `drop_cnt`: 0.
  - `ip_protocol`, `src_port`, `dst_port`: 0.
  - FSM: IDLE.
- `in_ready` is 1 from the first cycle after reset deasserts.
- Latency: `tuple_valid` rises on the cycle after the last required byte is accepted (L4 byte 3, or IP byte IHL*4−1).
- `err` is high for exactly one cycle: the cycle after the offending byte is accepted.
- An emit and a handshake of the prior tuple cannot coincide, because only one tuple is in flight per packet and sop is blocked while a tuple is pending.
- Reset asserted mid-packet: everything returns to reset values immediately and any pending tuple is lost. The packet remainder is discarded until the next sop.

## Structure
- A shared package `pkt_filter_pkg` holds:
  - `PROTO_TCP` = 6 and `PROTO_UDP` = 17.
  - IPv4 field offsets 9, 12 and 16.
  - Widths 72 and 18.
  - The FSM state enum.
- Sub-module `tuple_out_reg`: a 108-bit holding register with valid/ready. It is the only register stage between the parser and the filter core.

## Test plan
- UDP, ETH_HDR_BYTES=14, src 192.169.1.100, dst 192.168.1.100, ports 5→10, `tuple_ready`=1:
  - `ip_protocol` = 72'hC0A90164_C0A80164_11, `src_port` = 18'd5, `dst_port` = 18'd10.
  - `tuple_valid` high for 1 cycle, 1 cycle after L4 byte 3.
- Proto 100 with the same IPs: the tuple has byte 8'h64 and both ports 0, and is emitted 1 cycle after IP byte 19.
- TCP with IHL=6 (4 option bytes), ports 80→443: the ports are taken from L4 offset 0 and 2 after the options, giving `src_port` = 18'd80 and `dst_port` = 18'd443.
- `tuple_ready`=0 for 20 cycles with back-to-back packets:
  - The tuple holds stable and the first packet drains.
  - `in_ready` is 0 at the second sop until the handshake, then the second tuple follows.
- Malformed cases:
  - Version 6: `err` pulses, `drop_cnt` becomes 1, no tuple.
  - `in_eop` at IP byte 15: `err` pulses and `drop_cnt` becomes 2.
  - `drop_cnt` wraps from FFFF to 0.
- `rst` pulsed mid-L4: outputs return to 0 and no tuple is emitted. The next clean UDP packet produces the correct tuple.
